// File: rtl/pcihellocore_button_debouncer.sv
// pcihellocore_button_debouncer
// Conditions raw, bouncing, asynchronous key pins into a clean level word for
// the PIO's 32-bit input port, with one-cycle press/release strobes.
//
// Ports:
//   clk            system clock (only clock)
//   reset          synchronous, active-high reset
//   btn_raw        raw key pins, asynchronous to clk
//   btn_level      debounced level word, 1 = pressed, bits above NUM_BTNS are 0
//   press_pulse    one-cycle strobe on an accepted press
//   release_pulse  one-cycle strobe on an accepted release
//   btn_latched    sticky press flags (only with BTN_PRESS_LATCH_EN)
//   latch_clr      per-bit clear for btn_latched (only with BTN_PRESS_LATCH_EN)
//
// Optional feature macro: BTN_PRESS_LATCH_EN (sticky press latch). When the
// macro is undefined, btn_latched is tied to 0 and latch_clr is ignored.
module pcihellocore_button_debouncer #(
  parameter int unsigned NUM_BTNS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [31:0]         btn_level,
  output logic [NUM_BTNS-1:0] press_pulse,
  output logic [NUM_BTNS-1:0] release_pulse,
  output logic [NUM_BTNS-1:0] btn_latched,
  input  logic [NUM_BTNS-1:0] latch_clr
);

  localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Pin level of a released key; the synchroniser resets to it.
  localparam logic [NUM_BTNS-1:0] RELEASED = {NUM_BTNS{ACTIVE_LOW}};

  logic [NUM_BTNS-1:0] sync1_q;
  logic [NUM_BTNS-1:0] sync2_q;
  logic [NUM_BTNS-1:0] sample;
  logic [NUM_BTNS-1:0] level_q;
  logic [NUM_BTNS-1:0] level_d;
  logic [NUM_BTNS-1:0] press_d;
  logic [NUM_BTNS-1:0] release_d;
  logic [CNT_W-1:0]    cnt_q [NUM_BTNS];
  logic [CNT_W-1:0]    cnt_d [NUM_BTNS];

  // Polarity-normalised synchronised sample, 1 = pressed.
  assign sample = sync2_q ^ RELEASED;

  // Per-bit stability counter: any sample agreeing with the level restarts it.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      cnt_d[i] = '0;
      if (sample[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i]   = sample[i];
          press_d[i]   = sample[i];
          release_d[i] = ~sample[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser, counters, level and strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= RELEASED;
      sync2_q       <= RELEASED;
      level_q       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      cnt_q         <= '{default: '0};
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      level_q       <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      cnt_q         <= cnt_d;
    end
  end

  assign btn_level = 32'(level_q);

`ifdef BTN_PRESS_LATCH_EN
  // Sticky press flags; a press arriving with a clear still sets the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_latched <= '0;
    end else begin
      btn_latched <= (btn_latched & ~latch_clr) | press_pulse;
    end
  end
`else
  logic unused_latch_clr;
  assign unused_latch_clr = ^latch_clr;
  assign btn_latched      = '0;
`endif

endmodule

// File: tb/tb_pcihellocore_button_debouncer.sv
module tb_pcihellocore_button_debouncer;

  localparam int unsigned NB = 4;
  localparam int unsigned D  = 4;
  localparam bit          AL = 1'b1;
`ifdef BTN_PRESS_LATCH_EN
  localparam bit LATCH_EN = 1'b1;
`else
  localparam bit LATCH_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = 4'b1111;
  logic [NB-1:0] latch_clr = '0;
  logic [31:0]   btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [NB-1:0] btn_latched;

  pcihellocore_button_debouncer #(
    .NUM_BTNS(NB), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .btn_latched(btn_latched), .latch_clr(latch_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [NB-1:0] pr;
    logic [NB-1:0] rl;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  // Reference model: a key's pressed-state (1 = pressed) reaches the debouncer
  // two edges after the pin is first captured; a new level is accepted once D
  // consecutive such samples disagree with the current level.
  logic [NB-1:0] inflight[$];
  int unsigned   run [NB];
  logic [NB-1:0] m_level = '0;
  logic [NB-1:0] m_press_vis = '0;
  logic [NB-1:0] m_latch = '0;

  always @(posedge clk) begin
    logic [NB-1:0] seen, pr, rl, latch_next;
    cyc = cyc + 1;
    latch_next = LATCH_EN ? ((m_latch & ~latch_clr) | m_press_vis) : '0;
    if (reset) begin
      inflight = {};
      inflight.push_back('0);
      inflight.push_back('0);
      for (int i = 0; i < NB; i++) run[i] = 0;
      m_level = '0;
      m_press_vis = '0;
      m_latch = '0;
    end else begin
      seen = inflight.pop_front();
      pr = '0;
      rl = '0;
      for (int i = 0; i < NB; i++) begin
        if (seen[i] != m_level[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == D) begin
            run[i] = 0;
            if (seen[i]) pr[i] = 1'b1; else rl[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_level = (m_level | pr) & ~rl;
      if ((pr | rl) != '0) exp_q.push_back('{cyc: cyc, pr: pr, rl: rl});
      m_press_vis = pr;
      m_latch = latch_next;
      inflight.push_back(AL ? ~btn_raw : btn_raw);
    end
  end

  // Monitor: level and latch every cycle, strobes against the event queue.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (btn_level !== 32'(m_level)) begin
        errors++;
        $display("FAIL level cyc=%0d actual=%h required=%h", cyc, btn_level, 32'(m_level));
      end
      checks++;
      if (btn_latched !== m_latch) begin
        errors++;
        $display("FAIL latched cyc=%0d actual=%b required=%b", cyc, btn_latched, m_latch);
      end
      if ((press_pulse | release_pulse) !== '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_pulse cyc=%0d actual press=%b release=%b required none",
                   cyc, press_pulse, release_pulse);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.pr !== press_pulse || e.rl !== release_pulse) begin
            errors++;
            $display("FAIL pulse actual cyc=%0d press=%b release=%b required cyc=%0d press=%b release=%b",
                     cyc, press_pulse, release_pulse, e.cyc, e.pr, e.rl);
          end
        end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse actual none required cyc=%0d press=%b release=%b",
                 e.cyc, e.pr, e.rl);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Ticks until bit b of the level reads val; n = ticks taken, 0 on timeout.
  task automatic wait_level(input int b, input logic val, output int n);
    n = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (btn_level[b] === val) begin
        n = t;
        break;
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    btn_raw = 4'b1111;
    repeat (3) tick();
    chk("reset_level", btn_level, 32'h0);
    chk("reset_press", 32'(press_pulse), 32'h0);
    chk("reset_release", 32'(release_pulse), 32'h0);
    chk("reset_latched", 32'(btn_latched), 32'h0);
    mon_en = 1'b1;
    reset = 1'b0;
    repeat (3) tick();

    // Single press: accepted D+1 edges after the first capturing edge.
    btn_raw[0] = 1'b0;
    repeat (5) tick();
    chk("b0_before_accept", btn_level, 32'h0);
    tick();
    chk("b0_accept_level", btn_level, 32'h1);
    chk("b0_accept_pulse", 32'(press_pulse), 32'h1);
    tick();
    chk("b0_pulse_one_cycle", 32'(press_pulse), 32'h0);

    // Bounce on button 1, then hold.
    for (int ph = 0; ph < 4; ph++) begin
      btn_raw[1] = ph[0];
      repeat (3) tick();
    end
    btn_raw[1] = 1'b0;
    wait_level(1, 1'b1, n);
    chk("b1_bounce_latency", 32'(n), 32'(D + 2));

    // Buttons 2 and 3 together.
    btn_raw = 4'b1111;
    repeat (12) tick();
    btn_raw = 4'b0011;
    wait_level(2, 1'b1, n);
    chk("b23_press_pulse", 32'(press_pulse), 32'hC);
    chk("b23_level", btn_level, 32'hC);
    repeat (4) tick();
    btn_raw = 4'b1111;
    wait_level(2, 1'b0, n);
    chk("b23_release_pulse", 32'(release_pulse), 32'hC);
    chk("b23_release_level", btn_level, 32'h0);
    repeat (4) tick();

    // Reset mid-count while button 0 is held.
    btn_raw[0] = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_level", btn_level, 32'h0);
    wait_level(0, 1'b1, n);
    chk("rst_mid_reaccept", 32'(n), 32'(D + 2));
    chk("rst_mid_pulse", 32'(press_pulse), 32'h1);

    // Latch: clear coincident with the press strobe, then clear alone.
    btn_raw[0] = 1'b1;
    repeat (12) tick();
    btn_raw[0] = 1'b0;
    n = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (press_pulse[0] === 1'b1) begin
        n = 1;
        break;
      end
    end
    chk("latch_press_seen", 32'(n), 32'h1);
    latch_clr[0] = 1'b1;
    tick();
    chk("latch_set_wins", 32'(btn_latched[0]), 32'(LATCH_EN));
    tick();
    chk("latch_cleared", 32'(btn_latched[0]), 32'h0);
    latch_clr = '0;
    repeat (4) tick();

    // Randomised segments of random pin words with random hold lengths.
    for (int seg = 0; seg < 400; seg++) begin
      btn_raw = NB'($urandom);
      for (int h = 0, len = $urandom_range(1, 10); h < len; h++) begin
        latch_clr = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
        reset = ($urandom_range(0, 299) == 0);
        tick();
      end
      reset = 1'b0;
    end
    latch_clr = '0;
    btn_raw = 4'b1111;
    repeat (20) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
